// File: rtl/pcie_vc_injector_pkg.sv
// Shared constants and helpers for the PCIe VC injector.
// Arbitration policy is selected by PCIE_INJ_RR_ARB_EN (see pcie_vc_injector.sv).
package pcie_vc_injector_pkg;

    localparam int DEFAULT_DATA_W      = 6;
    localparam int DEFAULT_QDEPTH_LOG2 = 2;
    localparam int VC_BIT              = 5;
    localparam int NUM_PORTS           = 2;
    localparam int NUM_QUEUES          = 4;

    localparam int Q_VC0P0 = 0;
    localparam int Q_VC1P0 = 1;
    localparam int Q_VC0P1 = 2;
    localparam int Q_VC1P1 = 3;

    // Queue index layout is {port, vc}, matching the Q_* constants above.
    function automatic logic [1:0] q_index(input logic port, input logic vc);
        return {port, vc};
    endfunction

endpackage

// File: rtl/vc_queue.sv
// Small synchronous FIFO holding the words of one (VC, port) pair.
// Pushes to a full queue and pops from an empty queue are ignored.
module vc_queue
    import pcie_vc_injector_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int QDEPTH_LOG2 = DEFAULT_QDEPTH_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE   = QDEPTH_LOG2'(1);
    localparam logic [QDEPTH_LOG2:0]   CNT_ONE   = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2:0]   CNT_DEPTH = (QDEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr_r;
    logic [QDEPTH_LOG2-1:0] rd_ptr_r;
    logic [QDEPTH_LOG2:0]   count_r;
    logic                   do_push_s;
    logic                   do_pop_s;

    // status flags and qualified push/pop
    always_comb begin
        full      = (count_r == CNT_DEPTH);
        empty     = (count_r == {(QDEPTH_LOG2 + 1){1'b0}});
        head      = mem_r[rd_ptr_r];
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {QDEPTH_LOG2{1'b0}};
            rd_ptr_r <= {QDEPTH_LOG2{1'b0}};
            count_r  <= {(QDEPTH_LOG2 + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // storage; contents are don't-care while the queue is empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/pcie_vc_injector.sv
// Per-VC, per-port feeder for the PCIe transaction stage with pause/continue flow control.
// Define PCIE_INJ_RR_ARB_EN for round-robin VC arbitration; otherwise VC0 has fixed priority.
module pcie_vc_injector
    import pcie_vc_injector_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int QDEPTH_LOG2 = DEFAULT_QDEPTH_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [DATA_W-1:0] src_data_p0,
    input  logic [DATA_W-1:0] src_data_p1,
    input  logic              src_valid_p0,
    input  logic              src_valid_p1,
    output logic              src_ready_p0,
    output logic              src_ready_p1,
    input  logic              pause_VC0P0,
    input  logic              pause_VC1P0,
    input  logic              pause_VC0P1,
    input  logic              pause_VC1P1,
    input  logic              continue_VC0P0,
    input  logic              continue_VC1P0,
    input  logic              continue_VC0P1,
    input  logic              continue_VC1P1,
    output logic [DATA_W-1:0] data_p0,
    output logic [DATA_W-1:0] data_p1,
    output logic              valid_p0,
    output logic              valid_p1,
    output logic [3:0]        blocked,
    output logic [3:0]        q_empty
);

    logic [DATA_W-1:0] src_data_s [NUM_PORTS];
    logic [1:0]        src_valid_s;
    logic [1:0]        src_ready_s;
    logic [3:0]        pause_s;
    logic [3:0]        continue_s;
    logic [3:0]        push_s;
    logic [3:0]        pop_s;
    logic [3:0]        full_s;
    logic [3:0]        empty_s;
    logic [3:0]        elig_s;
    logic [DATA_W-1:0] head_s [NUM_QUEUES];
    logic [1:0]        grant_vc_s;
    logic [1:0]        grant_any_s;
    logic [DATA_W-1:0] gnt_head_s [NUM_PORTS];
    logic              e0_s;
    logic              e1_s;

    logic [3:0]        blocked_r;
    logic [DATA_W-1:0] data_r [NUM_PORTS];
    logic [1:0]        valid_r;
`ifdef PCIE_INJ_RR_ARB_EN
    logic [1:0]        last_vc_r;
`endif

    // gather named ports into indexed form
    always_comb begin
        pause_s             = 4'b0000;
        continue_s          = 4'b0000;
        pause_s[Q_VC0P0]    = pause_VC0P0;
        pause_s[Q_VC1P0]    = pause_VC1P0;
        pause_s[Q_VC0P1]    = pause_VC0P1;
        pause_s[Q_VC1P1]    = pause_VC1P1;
        continue_s[Q_VC0P0] = continue_VC0P0;
        continue_s[Q_VC1P0] = continue_VC1P0;
        continue_s[Q_VC0P1] = continue_VC0P1;
        continue_s[Q_VC1P1] = continue_VC1P1;
        src_data_s[0]       = src_data_p0;
        src_data_s[1]       = src_data_p1;
        src_valid_s         = {src_valid_p1, src_valid_p0};
    end

    // ready depends only on fullness of the selected queue, never on a same-edge pop
    always_comb begin
        src_ready_s = 2'b00;
        push_s      = 4'b0000;
        for (int p = 0; p < NUM_PORTS; p++) begin
            src_ready_s[p] = ~full_s[q_index(1'(p), src_data_s[p][VC_BIT])];
            push_s[q_index(1'(p), src_data_s[p][VC_BIT])] = src_valid_s[p] & src_ready_s[p];
        end
    end

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        vc_queue #(
            .DATA_W      (DATA_W),
            .QDEPTH_LOG2 (QDEPTH_LOG2)
        ) u_queue (
            .clk   (clk),
            .reset (reset),
            .push  (push_s[q]),
            .pop   (pop_s[q]),
            .din   (src_data_s[q >> 1]),
            .full  (full_s[q]),
            .empty (empty_s[q]),
            .head  (head_s[q])
        );
    end

    // a pause arriving this cycle blocks issue on the same edge
    always_comb begin
        elig_s = ~empty_s & ~blocked_r & ~pause_s & {4{active}};
    end

    // per-port VC arbitration and pop selection
    always_comb begin
        pop_s         = 4'b0000;
        grant_vc_s    = 2'b00;
        grant_any_s   = 2'b00;
        gnt_head_s[0] = data_r[0];
        gnt_head_s[1] = data_r[1];
        e0_s          = 1'b0;
        e1_s          = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            e0_s = elig_s[q_index(1'(p), 1'b0)];
            e1_s = elig_s[q_index(1'(p), 1'b1)];
`ifdef PCIE_INJ_RR_ARB_EN
            if (e0_s && e1_s) begin
                grant_vc_s[p] = ~last_vc_r[p];
            end else if (e1_s) begin
                grant_vc_s[p] = 1'b1;
            end else begin
                grant_vc_s[p] = 1'b0;
            end
`else
            if (e0_s) begin
                grant_vc_s[p] = 1'b0;
            end else if (e1_s) begin
                grant_vc_s[p] = 1'b1;
            end else begin
                grant_vc_s[p] = 1'b0;
            end
`endif
            grant_any_s[p] = e0_s | e1_s;
            if (grant_any_s[p]) begin
                pop_s[q_index(1'(p), grant_vc_s[p])] = 1'b1;
                gnt_head_s[p] = head_s[q_index(1'(p), grant_vc_s[p])];
            end else begin
                gnt_head_s[p] = data_r[p];
            end
        end
    end

    // pause/continue flags; pause wins when both pulse together
    always_ff @(posedge clk) begin
        if (reset) begin
            blocked_r <= 4'b0000;
        end else begin
            blocked_r <= pause_s | (blocked_r & ~continue_s);
        end
    end

    // output registers; data holds its last value when nothing is granted
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r   <= 2'b00;
            data_r[0] <= {DATA_W{1'b0}};
            data_r[1] <= {DATA_W{1'b0}};
        end else begin
            valid_r   <= grant_any_s;
            data_r[0] <= gnt_head_s[0];
            data_r[1] <= gnt_head_s[1];
        end
    end

`ifdef PCIE_INJ_RR_ARB_EN
    // last-served VC per port, updated only when a grant occurs
    always_ff @(posedge clk) begin
        if (reset) begin
            last_vc_r <= 2'b00;
        end else begin
            last_vc_r <= (grant_any_s & grant_vc_s) | (~grant_any_s & last_vc_r);
        end
    end
`endif

    assign data_p0      = data_r[0];
    assign data_p1      = data_r[1];
    assign valid_p0     = valid_r[0];
    assign valid_p1     = valid_r[1];
    assign blocked      = blocked_r;
    assign q_empty      = empty_s;
    assign src_ready_p0 = src_ready_s[0];
    assign src_ready_p1 = src_ready_s[1];

endmodule

// File: tb/tb_pcie_vc_injector.sv
// Randomized and directed bench for pcie_vc_injector with a queue-based reference model
// and a scoreboard monitor that checks every issued word.
module tb_pcie_vc_injector;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic [5:0] src_data_p0, src_data_p1;
    logic       src_valid_p0, src_valid_p1;
    logic       src_ready_p0, src_ready_p1;
    logic [3:0] pause_v, cont_v;
    logic [5:0] data_p0, data_p1;
    logic       valid_p0, valid_p1;
    logic [3:0] blocked, q_empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcie_vc_injector dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .src_data_p0    (src_data_p0),
        .src_data_p1    (src_data_p1),
        .src_valid_p0   (src_valid_p0),
        .src_valid_p1   (src_valid_p1),
        .src_ready_p0   (src_ready_p0),
        .src_ready_p1   (src_ready_p1),
        .pause_VC0P0    (pause_v[0]),
        .pause_VC1P0    (pause_v[1]),
        .pause_VC0P1    (pause_v[2]),
        .pause_VC1P1    (pause_v[3]),
        .continue_VC0P0 (cont_v[0]),
        .continue_VC1P0 (cont_v[1]),
        .continue_VC0P1 (cont_v[2]),
        .continue_VC1P1 (cont_v[3]),
        .data_p0        (data_p0),
        .data_p1        (data_p1),
        .valid_p0       (valid_p0),
        .valid_p1       (valid_p1),
        .blocked        (blocked),
        .q_empty        (q_empty)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queues indexed port*2+vc ----------------
    logic [5:0] mq [4][$];
    bit         mflag [4];
    bit         mlast [2];
    logic [5:0] exp_q [2][$];
    bit         exp_valid [2];
    bit         m_rdy [2];
    bit         m_el [4];
    int         m_g;
    logic [5:0] m_w;
    logic [5:0] m_sd [2];
    bit         m_sv [2];

    always @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < 4; q++) begin
                mq[q].delete();
                mflag[q] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                mlast[p] = 1'b0;
                exp_valid[p] = 1'b0;
                exp_q[p].delete();
            end
        end else begin
            m_sd[0] = src_data_p0; m_sd[1] = src_data_p1;
            m_sv[0] = src_valid_p0; m_sv[1] = src_valid_p1;
            for (int p = 0; p < 2; p++) m_rdy[p] = mq[p*2 + int'(m_sd[p][5])].size() < DEPTH;
            for (int q = 0; q < 4; q++)
                m_el[q] = (mq[q].size() != 0) && active && !mflag[q] && !pause_v[q];
            for (int p = 0; p < 2; p++) begin
                m_g = -1;
`ifdef PCIE_INJ_RR_ARB_EN
                if (m_el[p*2] && m_el[p*2+1]) m_g = mlast[p] ? 0 : 1;
                else if (m_el[p*2]) m_g = 0;
                else if (m_el[p*2+1]) m_g = 1;
`else
                if (m_el[p*2]) m_g = 0;
                else if (m_el[p*2+1]) m_g = 1;
`endif
                if (m_g >= 0) begin
                    m_w = mq[p*2 + m_g].pop_front();
                    exp_q[p].push_back(m_w);
                    exp_valid[p] = 1'b1;
                    mlast[p] = (m_g == 1);
                end else begin
                    exp_valid[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++)
                if (m_sv[p] && m_rdy[p]) mq[p*2 + int'(m_sd[p][5])].push_back(m_sd[p]);
            for (int q = 0; q < 4; q++)
                mflag[q] = pause_v[q] ? 1'b1 : (cont_v[q] ? 1'b0 : mflag[q]);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [5:0] mon_w;
    logic [3:0] mon_blk, mon_emp;
    always @(negedge clk) begin
        check("valid_p0", valid_p0, exp_valid[0]);
        check("valid_p1", valid_p1, exp_valid[1]);
        if (valid_p0 === 1'b1) begin
            if (exp_q[0].size() == 0) check("sb_p0_unexpected", data_p0, 32'hFFFF_FFFF);
            else begin mon_w = exp_q[0].pop_front(); check("data_p0", data_p0, mon_w); end
        end
        if (valid_p1 === 1'b1) begin
            if (exp_q[1].size() == 0) check("sb_p1_unexpected", data_p1, 32'hFFFF_FFFF);
            else begin mon_w = exp_q[1].pop_front(); check("data_p1", data_p1, mon_w); end
        end
        for (int q = 0; q < 4; q++) begin
            mon_blk[q] = mflag[q];
            mon_emp[q] = (mq[q].size() == 0);
        end
        check("blocked", blocked, mon_blk);
        check("q_empty", q_empty, mon_emp);
        if (reset === 1'b0) begin
            check("src_ready_p0", src_ready_p0, mq[int'(src_data_p0[5])].size() < DEPTH);
            check("src_ready_p1", src_ready_p1, mq[2 + int'(src_data_p1[5])].size() < DEPTH);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_valid_p0 = 1'b0; src_valid_p1 = 1'b0;
        pause_v = 4'h0; cont_v = 4'h0;
    endtask

    task automatic push(input bit p, input logic [5:0] d);
        if (p) begin src_valid_p1 = 1'b1; src_data_p1 = d; end
        else begin src_valid_p0 = 1'b1; src_data_p0 = d; end
        tick();
        src_valid_p0 = 1'b0; src_valid_p1 = 1'b0;
    endtask

    logic [5:0] arb_exp [4];

    initial begin
`ifdef PCIE_INJ_RR_ARB_EN
        arb_exp[0] = 6'h2C; arb_exp[1] = 6'h0A; arb_exp[2] = 6'h2D; arb_exp[3] = 6'h0B;
`else
        arb_exp[0] = 6'h0A; arb_exp[1] = 6'h0B; arb_exp[2] = 6'h2C; arb_exp[3] = 6'h2D;
`endif
        reset = 1'b1; active = 1'b0;
        src_data_p0 = 6'h00; src_data_p1 = 6'h00;
        idle_inputs();
        repeat (2) tick();
        reset = 1'b0;
        check("rst_data_p0", data_p0, 6'h00);
        check("rst_data_p1", data_p1, 6'h00);
        check("rst_q_empty", q_empty, 4'hF);
        check("rst_ready_p0", src_ready_p0, 1'b1);

        // basic issue: one-cycle latency, one-cycle valid
        active = 1'b1;
        push(1'b0, 6'h05);
        tick();
        check("basic_valid", valid_p0, 1'b1);
        check("basic_data", data_p0, 6'h05);
        tick();
        check("basic_valid_drop", valid_p0, 1'b0);

        // pause/continue on VC1P1
        active = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 6'h21 + 6'(i));
        active = 1'b1; pause_v[3] = 1'b1;
        tick();
        pause_v[3] = 1'b0;
        repeat (3) tick();
        check("pause_blocked3", blocked[3], 1'b1);
        check("pause_no_issue", valid_p1, 1'b0);
        cont_v[3] = 1'b1;
        tick();
        cont_v[3] = 1'b0;
        check("cont_no_issue_same_edge", valid_p1, 1'b0);
        tick();
        check("cont_first", data_p1, 6'h21);
        repeat (4) tick();

        // full queue with link down
        active = 1'b0;
        src_valid_p0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src_data_p0 = 6'(i + 1);
            if (i == 4) check("full_ready_low", src_ready_p0, 1'b0);
            tick();
        end
        src_valid_p0 = 1'b0;
        active = 1'b1;
        repeat (6) tick();
        check("full_ready_back", src_ready_p0, 1'b1);

        // arbitration between VCs of port 0
        active = 1'b0;
        push(1'b0, 6'h0A); push(1'b0, 6'h2C); push(1'b0, 6'h0B); push(1'b0, 6'h2D);
        active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arb_valid", valid_p0, 1'b1);
            check("arb_seq", data_p0, arb_exp[i]);
        end
        repeat (2) tick();

        // same-edge pause and continue: pause wins
        active = 1'b0;
        push(1'b0, 6'h07);
        active = 1'b1; pause_v[0] = 1'b1; cont_v[0] = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check("same_edge_blocked0", blocked[0], 1'b1);
        check("same_edge_no_issue", valid_p0, 1'b0);
        cont_v[0] = 1'b1;
        tick();
        cont_v[0] = 1'b0;
        repeat (3) tick();

        // reset mid-stream flushes queued words
        active = 1'b0;
        push(1'b0, 6'h11); push(1'b0, 6'h31); push(1'b1, 6'h12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_q_empty", q_empty, 4'hF);
        check("mid_rst_valid_p0", valid_p0, 1'b0);
        check("mid_rst_valid_p1", valid_p1, 1'b0);
        active = 1'b1;
        repeat (5) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 399) == 0);
            active       = ($urandom_range(0, 9) != 0);
            src_valid_p0 = 1'($urandom);
            src_valid_p1 = 1'($urandom);
            src_data_p0  = 6'($urandom);
            src_data_p1  = 6'($urandom);
            for (int q = 0; q < 4; q++) begin
                pause_v[q] = ($urandom_range(0, 19) == 0);
                cont_v[q]  = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        // drain
        reset = 1'b0; active = 1'b1;
        idle_inputs();
        cont_v = 4'hF;
        tick();
        cont_v = 4'h0;
        repeat (12) tick();
        check("drain_sb_p0", exp_q[0].size(), 0);
        check("drain_sb_p1", exp_q[1].size(), 0);
        check("drain_q_empty", q_empty, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
